// File: rtl/spi_regfile_slave_pkg.sv
// Shared types and helpers for the SPI register-file peripheral.
package spi_regfile_pkg;

    // Frame phases: one R/W bit, then the start address, then data words.
    typedef enum logic [1:0] {
        PhaseCmd,
        PhaseAddr,
        PhaseData
    } phase_e;

    // Encoding of the first bit of every frame.
    localparam logic RwWrite = 1'b1;
    localparam logic RwRead  = 1'b0;

    // Bits needed to count 0..value-1; never less than one.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 1;
        while ((32'd1 << width) < value) begin
            width++;
        end
        return width;
    endfunction

endpackage

// File: rtl/spi_regfile_slave_if.sv
// SPI pin bundle between a controller and the register-file peripheral.
interface spi_regfile_slave_if;

    logic nCS;
    logic COPI;
    logic CIPO;
    logic cipo_oe;

    modport master (
        output nCS,
        output COPI,
        input  CIPO,
        input  cipo_oe
    );

    modport slave (
        input  nCS,
        input  COPI,
        output CIPO,
        output cipo_oe
    );

endinterface

// File: rtl/spi_frame_ctrl.sv
// Frame sequencer: tracks CMD/ADDR/DATA phase, counts bits, holds and
// auto-increments the word address, and flags word boundaries.
module spi_frame_ctrl
    import spi_regfile_pkg::*;
#(
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DATA_W = 8
) (
    input  logic              SCLK,
    input  logic              frame_rst_n,
    input  logic              COPI,
    output logic [ADDR_W-1:0] addr,
    output logic              commit,
    output logic              load
);

    localparam int unsigned CntW = clog2((ADDR_W > DATA_W) ? ADDR_W : DATA_W);

    phase_e            phase_q;
    logic [CntW-1:0]   cnt_q;
    logic              rw_q;
    logic [ADDR_W-1:0] addr_q;
    logic              word_last;

    // The rising edge that carries the LSB of the current data word.
    assign word_last = (phase_q == PhaseData) && (cnt_q == CntW'(DATA_W - 1));

    // Phase FSM, bit counter and address register; nCS high clears the frame.
    always_ff @(posedge SCLK or negedge frame_rst_n) begin
        if (!frame_rst_n) begin
            phase_q <= PhaseCmd;
            cnt_q   <= '0;
            rw_q    <= RwRead;
            addr_q  <= '0;
        end else begin
            case (phase_q)
                PhaseCmd: begin
                    rw_q    <= COPI;
                    cnt_q   <= '0;
                    phase_q <= PhaseAddr;
                end
                PhaseAddr: begin
                    addr_q <= (addr_q << 1) | ADDR_W'(COPI);
                    if (cnt_q == CntW'(ADDR_W - 1)) begin
                        cnt_q   <= '0;
                        phase_q <= PhaseData;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                PhaseData: begin
                    if (word_last) begin
                        cnt_q  <= '0;
                        // Burst: wrap modulo 2^ADDR_W.
                        addr_q <= addr_q + ADDR_W'(1);
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                default: begin
                    phase_q <= PhaseCmd;
                end
            endcase
        end
    end

    assign addr   = addr_q;
    assign commit = word_last && (rw_q == RwWrite);
    // Counter sits at zero in DATA exactly between the address (or a word's
    // LSB) edge and the next rising edge: the falling edge there loads.
    assign load   = (phase_q == PhaseData) && (cnt_q == '0) && (rw_q == RwRead);

endmodule

// File: rtl/spi_regfile_slave.sv
// SPI mode-0 register file: write/read with burst auto-increment and a
// sticky out-of-range address flag. Registers appear as one flat bus.
module spi_regfile_slave
    import spi_regfile_pkg::*;
#(
    parameter int unsigned       NUM_REGS  = 5,
    parameter int unsigned       DATA_W    = 8,
    parameter int unsigned       ADDR_W    = 7,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                       SCLK,
    input  logic                       rst_n,
    spi_regfile_slave_if.slave         spi,
    output logic [NUM_REGS*DATA_W-1:0] regs,
    output logic                       err_addr
);

    localparam int unsigned ShW = DATA_W - 1;

    logic              frame_rst_n;
    logic [ADDR_W-1:0] addr;
    logic              commit;
    logic              load;
    logic              addr_ok;
    logic [ShW-1:0]    wsh_q;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic [DATA_W-1:0] rsh_q;
    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic              oe_q;
    logic              err_wr_q;
    logic              err_rd_q;

    // Frame logic is held clear while deselected or in reset.
    assign frame_rst_n = rst_n & ~spi.nCS;

    spi_frame_ctrl #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_frame_ctrl (
        .SCLK        (SCLK),
        .frame_rst_n (frame_rst_n),
        .COPI        (spi.COPI),
        .addr        (addr),
        .commit      (commit),
        .load        (load)
    );

    assign addr_ok = (32'(addr) < NUM_REGS);

    // Collect the leading DATA_W-1 bits; the LSB joins them on the commit edge.
    always_ff @(posedge SCLK or negedge rst_n) begin
        if (!rst_n) begin
            wsh_q <= '0;
        end else begin
            wsh_q <= (wsh_q << 1) | ShW'(spi.COPI);
        end
    end

    assign wdata = {wsh_q, spi.COPI};

    // Register array: written on the rising edge carrying a word's LSB.
    always_ff @(posedge SCLK or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= RESET_VAL;
            end
        end else if (commit) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                if (addr == ADDR_W'(i)) begin
                    regs_q[i] <= wdata;
                end
            end
        end
    end

    // Write to an unimplemented address: word dropped, flag latched.
    always_ff @(posedge SCLK or negedge rst_n) begin
        if (!rst_n) begin
            err_wr_q <= 1'b0;
        end else if (commit && !addr_ok) begin
            err_wr_q <= 1'b1;
        end
    end

    // Read mux; unimplemented addresses read as zero.
    always_comb begin
        rdata = '0;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            if (addr == ADDR_W'(i)) begin
                rdata = regs_q[i];
            end
        end
    end

    // CIPO shifter: load a word or advance one bit on each falling edge.
    always_ff @(negedge SCLK or negedge frame_rst_n) begin
        if (!frame_rst_n) begin
            rsh_q <= '0;
            oe_q  <= 1'b0;
        end else if (load) begin
            rsh_q <= rdata;
            oe_q  <= 1'b1;
        end else begin
            rsh_q <= rsh_q << 1;
        end
    end

    // Read from an unimplemented address latches the flag at load time.
    always_ff @(negedge SCLK or negedge rst_n) begin
        if (!rst_n) begin
            err_rd_q <= 1'b0;
        end else if (load && !addr_ok) begin
            err_rd_q <= 1'b1;
        end
    end

    // Flatten the array onto the consumer bus.
    always_comb begin
        regs = '0;
        for (int i = 0; i < int'(NUM_REGS); i++) begin
            regs[i*DATA_W +: DATA_W] = regs_q[i];
        end
    end

    assign spi.CIPO    = oe_q & rsh_q[DATA_W-1];
    assign spi.cipo_oe = oe_q;
    assign err_addr    = err_wr_q | err_rd_q;

endmodule
